// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo
// Description : Byte FIFO feeding a serial transmitter. Show-ahead read port
//               (head byte always presented on tx_data), occupancy count,
//               full flag and sticky overflow/underflow error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    // producer side
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    output logic          full,
    output logic [AW:0]   count,
    // error flags
    output logic          overflow,
    output logic          underflow,
    input  logic          clr_err,
    // transmitter side
    output logic          tx_ready,
    output logic [7:0]    tx_data,
    input  logic          tx_rd
);

    // Occupancy value that means "every entry holds a byte".
    localparam logic [AW:0]   c_depth_cnt = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_cnt_one   = (AW+1)'(1);
    localparam logic [AW-1:0] c_ptr_one   = AW'(1);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wp;
    logic [AW-1:0] r_rp;
    logic [AW:0]   r_count;
    logic          r_overflow;
    logic          r_underflow;

    logic          w_full;
    logic          w_empty;
    logic          w_wr_acc;
    logic          w_rd_acc;

    // Status is taken from the registered count, so full/empty reflect the
    // state before the current edge; a write into a full FIFO is dropped even
    // when a pop is accepted in the same cycle.
    assign w_full   = (r_count == c_depth_cnt);
    assign w_empty  = (r_count == '0);
    assign w_wr_acc = wr_en & ~w_full;
    assign w_rd_acc = tx_rd & ~w_empty;

    // Storage array: written only on accepted writes, never reset.
    always_ff @(posedge clk) begin
        if (w_wr_acc) begin
            r_mem[r_wp] <= wr_data;
        end
    end

    // Pointers advance on accepted operations and wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wp <= r_wp + c_ptr_one;
            end
            if (w_rd_acc) begin
                r_rp <= r_rp + c_ptr_one;
            end
        end
    end

    // Occupancy: simultaneous accepted write and pop leave it unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else begin
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky error flags; a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  & ~clr_err) | (wr_en & w_full);
            r_underflow <= (r_underflow & ~clr_err) | (tx_rd & w_empty);
        end
    end

    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign tx_ready  = ~w_empty;
    assign tx_data   = r_mem[r_rp];

endmodule
`default_nettype wire

// File: tb/tb_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_tx_fifo
// Description : Self-checking bench for tx_fifo. Accepted writes are pushed
//               to a scoreboard queue; every pop compares the head byte with
//               the queue front. Ends with a serial transmitter draining "HI\n".
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int CPB   = 867;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [7:0]    wr_data;
    logic          full;
    logic [AW:0]   count;
    logic          overflow;
    logic          underflow;
    logic          clr_err;
    logic          tx_ready;
    logic [7:0]    tx_data;
    logic          tx_rd;

    logic          line = 1'b1;

    int            checks   = 0;
    int            failures = 0;

    logic [7:0]    sb[$];
    logic [7:0]    line_exp[$];
    int            m_count;
    bit            m_ovf;
    bit            m_unf;

    tx_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow),
        .clr_err   (clr_err),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_rd     (tx_rd)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and advance the reference model. Accepted
    // writes go onto the scoreboard; the caller pops it when it checks data.
    task automatic drive(input bit we, input logic [7:0] d, input bit rd, input bit clr);
        bit wacc;
        bit racc;
        wacc  = we && (m_count != DEPTH);
        racc  = rd && (m_count != 0);
        m_ovf = (m_ovf && !clr) || (we && (m_count == DEPTH));
        m_unf = (m_unf && !clr) || (rd && (m_count == 0));
        if (wacc) sb.push_back(d);
        m_count = m_count + int'(wacc) - int'(racc);
        wr_en   = we;
        wr_data = d;
        tx_rd   = rd;
        clr_err = clr;
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        tx_rd   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic model_reset();
        sb.delete();
        m_count = 0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    task automatic test_reset();
        wr_en = 1'b0; wr_data = 8'h00; tx_rd = 1'b0; clr_err = 1'b0;
        rst = 1'b1;
        #12;
        checks++;
        if (count !== '0 || tx_ready !== 1'b0 || full !== 1'b0) begin
            failures++;
            $display("FAIL reset_async count=%0d tx_ready=%b full=%b, want 0/0/0", count, tx_ready, full);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if (count !== '0 || tx_ready !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_state count=%0d rdy=%b full=%b ovf=%b unf=%b, want all 0",
                     count, tx_ready, full, overflow, underflow);
        end
    endtask

    task automatic test_single();
        logic [7:0] exp;
        drive(1'b1, 8'h41, 1'b0, 1'b0);
        checks++;
        if (tx_ready !== 1'b1 || tx_data !== 8'h41 || count !== 5'd1) begin
            failures++;
            $display("FAIL single_write rdy=%b data=%h count=%0d, want 1/41/1", tx_ready, tx_data, count);
        end
        exp = sb.pop_front();
        checks++;
        if (tx_data !== exp) begin
            failures++;
            $display("FAIL single_pop_data got=%h want=%h", tx_data, exp);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd0 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_drain count=%0d rdy=%b, want 0/0", count, tx_ready);
        end
    endtask

    task automatic test_fill_overflow();
        logic [7:0] exp;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'(i), 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL fill count=%0d full=%b ovf=%b, want 16/1/0", count, full, overflow);
        end
        drive(1'b1, 8'hFF, 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || count !== 5'd16) begin
            failures++;
            $display("FAIL overflow_set ovf=%b count=%0d, want 1/16", overflow, count);
        end
        // clear, then write+pop while full: write must still be dropped
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            failures++;
            $display("FAIL overflow_clear ovf=%b want 0", overflow);
        end
        exp = sb.pop_front();
        checks++;
        if (tx_data !== exp) begin
            failures++;
            $display("FAIL full_wr_rd_data got=%h want=%h", tx_data, exp);
        end
        drive(1'b1, 8'hEE, 1'b1, 1'b0);
        checks++;
        if (count !== 5'(m_count) || overflow !== 1'b1 || full !== 1'b0) begin
            failures++;
            $display("FAIL full_wr_rd count=%0d ovf=%b full=%b, want %0d/1/0", count, overflow, full, m_count);
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if (tx_ready !== 1'b1 || tx_data !== exp) begin
                failures++;
                $display("FAIL fill_drain rdy=%b got=%h want=%h", tx_ready, tx_data, exp);
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        checks++;
        if (count !== '0 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL fill_empty count=%0d rdy=%b, want 0/0", count, tx_ready);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp;
        for (int i = 0; i < 5; i++) drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            exp = sb.pop_front();
            checks++;
            if (tx_data !== exp) begin
                failures++;
                $display("FAIL b2b_data got=%h want=%h", tx_data, exp);
            end
            drive(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
            checks++;
            if (count !== 5'd5) begin
                failures++;
                $display("FAIL b2b_count got=%0d want=5", count);
            end
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if (tx_data !== exp) begin
                failures++;
                $display("FAIL b2b_drain got=%h want=%h", tx_data, exp);
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] exp;
        for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'h10 + 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            exp = sb.pop_front();
            checks++;
            if (tx_data !== exp) begin
                failures++;
                $display("FAIL wrap_pop got=%h want=%h", tx_data, exp);
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
        for (int i = 0; i < 10; i++) drive(1'b1, 8'hA0 + 8'(i), 1'b0, 1'b0);
        checks++;
        if (full !== 1'b1 || count !== 5'd16 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL wrap_full count=%0d full=%b ovf=%b, want 16/1/0", count, full, overflow);
        end
        while (sb.size() > 0) begin
            exp = sb.pop_front();
            checks++;
            if (tx_data !== exp) begin
                failures++;
                $display("FAIL wrap_drain got=%h want=%h", tx_data, exp);
            end
            drive(1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_underflow();
        logic [7:0] exp;
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if (underflow !== 1'b1 || count !== '0) begin
            failures++;
            $display("FAIL underflow_set unf=%b count=%0d, want 1/0", underflow, count);
        end
        // clear coinciding with a new empty pop: flag stays set
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (underflow !== 1'b1) begin
            failures++;
            $display("FAIL underflow_set_wins unf=%b want 1", underflow);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (underflow !== 1'b0) begin
            failures++;
            $display("FAIL underflow_clear unf=%b want 0", underflow);
        end
        // pop and write into an empty FIFO: write accepted, pop ignored
        drive(1'b1, 8'h77, 1'b1, 1'b0);
        checks++;
        if (count !== 5'd1 || underflow !== 1'b1 || tx_data !== 8'h77) begin
            failures++;
            $display("FAIL empty_wr_rd count=%0d unf=%b data=%h, want 1/1/77", count, underflow, tx_data);
        end
        exp = sb.pop_front();
        drive(1'b0, 8'h00, 1'b1, 1'b1);
        checks++;
        if (count !== '0 || underflow !== 1'b0 || exp !== 8'h77) begin
            failures++;
            $display("FAIL empty_wr_rd_drain count=%0d unf=%b, want 0/0", count, underflow);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (count !== '0 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid count=%0d rdy=%b, want 0/0", count, tx_ready);
        end
        #1;
        rst = 1'b0;
        model_reset();
        @(posedge clk); #1;
        drive(1'b1, 8'h5A, 1'b0, 1'b0);
        checks++;
        if (count !== 5'd1 || tx_data !== 8'h5A || dut.r_mem[0] !== 8'h5A) begin
            failures++;
            $display("FAIL reset_first_write count=%0d data=%h mem0=%h, want 1/5a/5a",
                     count, tx_data, dut.r_mem[0]);
        end
        void'(sb.pop_front());
        drive(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_serial();
        logic [7:0] msg [3];
        msg[0] = 8'h48; msg[1] = 8'h49; msg[2] = 8'h0A;
        for (int i = 0; i < 3; i++) begin
            line_exp.push_back(msg[i]);
            drive(1'b1, msg[i], 1'b0, 1'b0);
        end
        fork
            begin : consumer
                logic [7:0] byte_q;
                logic [7:0] exp;
                for (int f = 0; f < 3; f++) begin
                    int waitc;
                    waitc = 0;
                    while (tx_ready !== 1'b1 && waitc < 100) begin
                        @(posedge clk); #1; waitc++;
                    end
                    byte_q = tx_data;
                    exp    = (sb.size() > 0) ? sb.pop_front() : 8'hXX;
                    checks++;
                    if (tx_ready !== 1'b1 || byte_q !== exp) begin
                        failures++;
                        $display("FAIL serial_head rdy=%b got=%h want=%h", tx_ready, byte_q, exp);
                    end
                    drive(1'b0, 8'h00, 1'b1, 1'b0);
                    if (f == 2) begin
                        checks++;
                        if (tx_ready !== 1'b0 || count !== '0) begin
                            failures++;
                            $display("FAIL serial_ready_drop rdy=%b count=%0d, want 0/0", tx_ready, count);
                        end
                    end
                    line = 1'b0;
                    repeat (CPB) @(posedge clk);
                    for (int b = 0; b < 8; b++) begin
                        line = byte_q[b];
                        repeat (CPB) @(posedge clk);
                    end
                    line = 1'b1;
                    repeat (CPB) @(posedge clk);
                    #1;
                end
            end
            begin : receiver
                logic [7:0] rx;
                logic [7:0] exp;
                for (int f = 0; f < 3; f++) begin
                    int waitc;
                    waitc = 0;
                    while (line !== 1'b0 && waitc < 20000) begin
                        @(negedge clk); waitc++;
                    end
                    exp = (line_exp.size() > 0) ? line_exp.pop_front() : 8'hXX;
                    if (line !== 1'b0) begin
                        checks++;
                        failures++;
                        $display("FAIL serial_start_timeout frame=%0d line=%b want 0", f, line);
                        break;
                    end
                    repeat (CPB / 2) @(negedge clk);
                    for (int b = 0; b < 8; b++) begin
                        repeat (CPB) @(negedge clk);
                        rx[b] = line;
                    end
                    repeat (CPB) @(negedge clk);
                    checks++;
                    if (rx !== exp || line !== 1'b1) begin
                        failures++;
                        $display("FAIL serial_frame frame=%0d got=%h stop=%b want=%h stop=1", f, rx, line, exp);
                    end
                end
            end
        join
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_back_to_back();
        test_wrap();
        test_underflow();
        test_reset_mid();
        test_serial();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/tx_fifo.md
TX_FIFO -- requirements
Module: tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16: number of byte entries; power of two, 2..256.
REQ-002 Parameter AW, default 4: pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  producer write strobe; one byte per cycle when high.
REQ-006 wr_data  input  8  byte to enqueue, sampled when wr_en=1.
REQ-007 full  output  1  high when the FIFO holds DEPTH bytes.
REQ-008 count  output  AW+1  number of stored bytes, 0..DEPTH.
REQ-009 overflow  output  1  sticky flag: a write was dropped.
REQ-010 underflow  output  1  sticky flag: a pop arrived while empty.
REQ-011 clr_err  input  1  synchronous clear of overflow and underflow.
REQ-012 tx_ready  output  1  high when the FIFO is non-empty; drives the serial transmitter's request.
REQ-013 tx_data  output  8  head-of-queue byte, valid whenever tx_ready=1.
REQ-014 tx_rd  input  1  one-cycle pop pulse from the serial transmitter.

Function
REQ-015 Storage: DEPTH x 8 register array, write pointer wp and read pointer rp (AW bits each), plus count register (AW+1 bits).
REQ-016 Show-ahead read: tx_data SHALL equal mem[rp] combinationally; no read latency.
REQ-017 tx_ready SHALL be (count != 0), derived from registered count; full SHALL be (count == DEPTH).
REQ-018 Write accepted when wr_en=1 and full=0 at the edge: mem[wp] <= wr_data, wp <= wp+1 mod DEPTH.
REQ-019 Write with full=1 SHALL be dropped, memory and wp unchanged, overflow <= 1; this holds even if tx_rd=1 in the same cycle (full evaluated pre-edge).
REQ-020 Pop accepted when tx_rd=1 and count!=0: rp <= rp+1 mod DEPTH.
REQ-021 Pop with count=0 SHALL be ignored, rp unchanged, underflow <= 1; a same-cycle write into the empty FIFO is still accepted.
REQ-022 Count update: +1 on accepted write only, -1 on accepted pop only, unchanged when both or neither are accepted.
REQ-023 Pointer wrap: DEPTH-1 -> 0 with no gap; wrap SHALL NOT affect count.
REQ-024 Write-to-tx_ready latency: one cycle (byte written at edge N; tx_ready=1 and tx_data valid after edge N).
REQ-025 Consumer handshake: the consumer samples tx_data when idle and tx_ready=1 and pulses tx_rd on the following cycle; tx_data and tx_ready SHALL stay stable until that pop unless a write is the only event.
REQ-026 A byte SHALL leave the FIFO only on an accepted pop; no byte is lost or duplicated except for writes dropped under REQ-019.
REQ-027 clr_err=1 clears both sticky flags at the edge; if a new error event occurs in the same cycle, the flag SHALL be set (set wins).

Reset
REQ-028 rst=1 SHALL asynchronously force wp=0, rp=0, count=0, overflow=0, underflow=0, so that tx_ready=0 and full=0.
REQ-029 Memory contents need not be reset; tx_data is don't-care while tx_ready=0.
REQ-030 Reset mid-operation SHALL discard all queued bytes; the first write after deassertion lands at entry 0.

Verification
REQ-031 Reset, then write 0x41 once -> tx_ready=1 and tx_data=0x41 one cycle later, count=1; pulse tx_rd -> count=0 and tx_ready=0.
REQ-032 Write 16 bytes 0x00..0x0F with no pops -> full=1, count=16; a 17th write of 0xFF -> overflow=1, and popping yields exactly 0x00..0x0F in order.
REQ-033 With count=5, assert wr_en and tx_rd together for 3 cycles -> count stays 5; popped bytes are the first three stored, in order.
REQ-034 Fill to 16, then pop 10 and write 10 new bytes (0xA0..0xA9) -> wp and rp wrap; drain returns the remaining 6 old bytes, then 0xA0..0xA9.
REQ-035 Pulse tx_rd while empty -> underflow=1, count=0; pulse clr_err -> underflow=0.
REQ-036 Load "HI\n" (0x48, 0x49, 0x0A) connected to the serial transmitter at 867 clocks per bit -> the line carries three 10-bit frames in order and tx_ready drops after the third pop.
